cu_command_arbiter: RTL and testbench
=====================================

Name: cu_command_arbiter

Overview:
- Parametrised N-compute-unit command arbiter for the next-generation AFU, where the compute-unit control instantiates NUM_CU parallel units instead of one.
- Merges per-CU command requests into the single read/write command stream toward afu_control.
- Issues tags, enforces a credit limit, and routes responses back to the originating CU.
- Sits between the compute units and afu_control in the AFU top level.

Parameters:
NUM_CU, 4, number of compute-unit request channels (power of two, 2..16)
CMD_WIDTH, 128, width of one flattened command line
TAG_WIDTH, 6, tag width; tag space is 2**TAG_WIDTH
CREDITS, 32, maximum outstanding commands (must be <= 2**TAG_WIDTH)
PRIORITY_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins)

Ports:
clock  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
enabled_in  in  1  AFU running; gates new grants only
req_valid  in  NUM_CU  per-CU command request
req_cmd  in  NUM_CU*CMD_WIDTH  per-CU command; CU i occupies slice [i*CMD_WIDTH +: CMD_WIDTH]
req_ready  out  NUM_CU  one-hot grant; a transfer occurs when req_valid[i] and req_ready[i] are both high
buffer_full_in  in  1  downstream command buffer almost-full
cmd_valid_out  out  1  issued command valid
cmd_out  out  CMD_WIDTH  issued command
cmd_tag_out  out  TAG_WIDTH  tag of issued command
cmd_cu_id_out  out  $clog2(NUM_CU)  source CU of issued command
rsp_valid_in  in  1  response arrived
rsp_tag_in  in  TAG_WIDTH  tag of response
rsp_valid_out  out  NUM_CU  one-hot response delivered to the owning CU
rsp_tag_out  out  TAG_WIDTH  tag of delivered response
outstanding_count  out  $clog2(CREDITS+1)  commands in flight
tag_error  out  1  sticky: response received for a tag not in flight

Behaviour:
- Reset: all outputs 0; round-robin pointer 0; next_tag 0; in-flight bit vector cleared; tag owner table content is don't-care. Reset mid-operation drops all in-flight state; responses arriving later set tag_error.
- Grant condition, evaluated combinationally in the current cycle: enabled_in & !buffer_full_in & (outstanding_count < CREDITS) & !inflight[next_tag] & |req_valid.
  - When the condition holds, exactly one req_ready bit is high.
  - Otherwise req_ready = 0.
- req_ready depends on req_valid (combinational). CUs must not make req_valid depend on req_ready.
- Round-robin (PRIORITY_MODE=0): search starts at the pointer. After a grant to CU g, the pointer becomes (g+1) mod NUM_CU. The pointer is unchanged when there is no grant.
- Fixed priority (PRIORITY_MODE=1): lowest requesting index wins; the pointer is ignored.
- Issue, registered with 1-cycle latency: the cycle after grant to CU g:
  - cmd_valid_out = 1, cmd_out = req_cmd slice g, cmd_cu_id_out = g, cmd_tag_out = the next_tag used.
  - On the grant edge: owner[next_tag] <= g, inflight[next_tag] <= 1, next_tag increments and wraps mod 2**TAG_WIDTH.
  - cmd_valid_out is 0 in cycles without a grant; other cmd outputs hold.
- Tag collision: if inflight[next_tag] is set, grants stall until that tag's response clears the bit. next_tag never skips.
- Response, 1-cycle latency: rsp_valid_in with tag t and inflight[t]=1:
  - Next cycle: rsp_valid_out[owner[t]] = 1 and rsp_tag_out = t.
  - inflight[t] clears on that edge.
- Invalid response: rsp_valid_in with inflight[t]=0:
  - No rsp_valid_out, tag_error <= 1.
  - tag_error stays set until rst; it feeds the external_errors vector.
- Responses are routed regardless of enabled_in and buffer_full_in.
- outstanding_count: +1 on issue, -1 on a valid response, unchanged when both happen in the same cycle. It never exceeds CREDITS and never underflows, because invalid responses do not decrement it.
- Same-cycle grant and response on the same tag cannot occur, since a grant requires that tag to be not in flight.
- When enabled_in deasserts mid-stream, an issue already registered completes; no new grants follow.

Test Plan:
- Round-robin fairness: NUM_CU=4, all req_valid=1 continuously, no responses, CREDITS=32 -> grants to CU 0,1,2,3,0,1,... with tags 0,1,2,...; after 32 issues req_ready=0 and outstanding_count=32.
- Credit return: from the full state, rsp_valid_in tag=5 -> next cycle rsp_valid_out=4'b0010 (CU1), rsp_tag_out=5; outstanding_count=31; one new grant (tag 32) follows in the same cycle as that decrement.
- Simultaneous issue and response: outstanding_count=10, grant and a valid response on the same cycle -> count stays 10; both cmd_valid_out and rsp_valid_out pulse on the next cycle.
- Fixed priority with backpressure: PRIORITY_MODE=1, req_valid=4'b1010 -> CU1 granted each cycle, CU3 starved; buffer_full_in=1 -> req_ready=0 and cmd_valid_out=0 one cycle later.
- Tag wrap and collision: TAG_WIDTH=2, CREDITS=4, issue tags 0..3, respond only tag 1 -> outstanding_count=3 but next_tag=0 is in flight, so no grant; respond tag 0 -> next grant uses tag 0.
- Error and reset: rsp_valid_in with tag 7 not in flight -> tag_error=1, no rsp_valid_out; assert rst mid-burst -> all outputs 0 immediately; a post-reset response sets tag_error again.

Source files
------------

// File: rtl/cu_command_arbiter_if.sv
// Bundle between the compute units / afu_control and the command arbiter.
// The arbiter takes the slave modport; the CU/afu_control side takes master.
interface cu_command_arbiter_if #(
   parameter int NUM_CU    = 4,
   parameter int CMD_WIDTH = 128,
   parameter int TAG_WIDTH = 6,
   parameter int CREDITS   = 32
);

   localparam int CU_ID_W = $clog2(NUM_CU);
   localparam int CNT_W   = $clog2(CREDITS + 1);

   logic                        enabled_in;
   logic [NUM_CU-1:0]           req_valid;
   logic [NUM_CU*CMD_WIDTH-1:0] req_cmd;
   logic [NUM_CU-1:0]           req_ready;
   logic                        buffer_full_in;
   logic                        cmd_valid_out;
   logic [CMD_WIDTH-1:0]        cmd_out;
   logic [TAG_WIDTH-1:0]        cmd_tag_out;
   logic [CU_ID_W-1:0]          cmd_cu_id_out;
   logic                        rsp_valid_in;
   logic [TAG_WIDTH-1:0]        rsp_tag_in;
   logic [NUM_CU-1:0]           rsp_valid_out;
   logic [TAG_WIDTH-1:0]        rsp_tag_out;
   logic [CNT_W-1:0]            outstanding_count;
   logic                        tag_error;

   modport slave (
      input  enabled_in, req_valid, req_cmd, buffer_full_in, rsp_valid_in, rsp_tag_in,
      output req_ready, cmd_valid_out, cmd_out, cmd_tag_out, cmd_cu_id_out,
             rsp_valid_out, rsp_tag_out, outstanding_count, tag_error
   );

   modport master (
      output enabled_in, req_valid, req_cmd, buffer_full_in, rsp_valid_in, rsp_tag_in,
      input  req_ready, cmd_valid_out, cmd_out, cmd_tag_out, cmd_cu_id_out,
             rsp_valid_out, rsp_tag_out, outstanding_count, tag_error
   );

endinterface

// File: rtl/cu_command_arbiter.sv
// Merges NUM_CU compute-unit command channels into one tagged, credit-limited
// command stream toward afu_control and routes responses back to the owning CU.
module cu_command_arbiter #(
   parameter int NUM_CU        = 4,
   parameter int CMD_WIDTH     = 128,
   parameter int TAG_WIDTH     = 6,
   parameter int CREDITS       = 32,
   parameter int PRIORITY_MODE = 0
) (
   input logic                  clock,
   input logic                  rst,
   cu_command_arbiter_if.slave  bus
);

   localparam int CU_ID_W   = $clog2(NUM_CU);
   localparam int CNT_W     = $clog2(CREDITS + 1);
   localparam int TAG_SPACE = 2 ** TAG_WIDTH;

   logic [CU_ID_W-1:0]   rr_ptr;
   logic [TAG_WIDTH-1:0] next_tag;
   logic [TAG_SPACE-1:0] inflight;
   logic [CU_ID_W-1:0]   owner [TAG_SPACE];

   logic                 grant_ok;
   logic                 grant_any;
   logic                 grant;
   logic [CU_ID_W-1:0]   grant_idx;
   logic [CU_ID_W-1:0]   search_base;
   logic [CU_ID_W-1:0]   search_idx;
   logic                 rsp_hit;
   logic                 rsp_miss;
   logic [NUM_CU-1:0]    rsp_onehot;

   // A grant also needs the next tag to be free: next_tag never skips a busy tag.
   assign grant_ok = !rst && bus.enabled_in && !bus.buffer_full_in
                     && (bus.outstanding_count < CNT_W'(CREDITS))
                     && !inflight[next_tag];
   assign grant    = grant_ok && grant_any;

   assign rsp_hit  = bus.rsp_valid_in &&  inflight[bus.rsp_tag_in];
   assign rsp_miss = bus.rsp_valid_in && !inflight[bus.rsp_tag_in];

   always_comb begin
      // NOTE: every variable written here gets a default first so no latch is inferred.
      grant_any   = 1'b0;
      grant_idx   = '0;
      search_idx  = '0;
      search_base = '0;
      if (PRIORITY_MODE == 0) search_base = rr_ptr;
      // NUM_CU is a power of two, so the index wraps by truncation.
      for (int i = 0; i < NUM_CU; i++) begin
         search_idx = search_base + CU_ID_W'(i);
         if (!grant_any && bus.req_valid[search_idx]) begin
            grant_any = 1'b1;
            grant_idx = search_idx;
         end
      end
   end

   always_comb begin
      bus.req_ready = '0;
      if (grant) bus.req_ready[grant_idx] = 1'b1;
   end

   always_comb begin
      rsp_onehot = '0;
      if (rsp_hit) rsp_onehot[owner[bus.rsp_tag_in]] = 1'b1;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         rr_ptr   <= '0;
         next_tag <= '0;
         inflight <= '0;
      end else begin
         if (grant) begin
            inflight[next_tag] <= 1'b1;
            next_tag           <= next_tag + TAG_WIDTH'(1);
            if (PRIORITY_MODE == 0) rr_ptr <= grant_idx + CU_ID_W'(1);
         end
         if (rsp_hit) inflight[bus.rsp_tag_in] <= 1'b0;
      end
   end

   // NOTE: the owner table has no reset; an entry is only read while its inflight bit is set.
   always_ff @(posedge clock) begin
      if (grant) owner[next_tag] <= grant_idx;
   end

   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         bus.cmd_valid_out <= 1'b0;
         bus.cmd_out       <= '0;
         bus.cmd_tag_out   <= '0;
         bus.cmd_cu_id_out <= '0;
      end else begin
         bus.cmd_valid_out <= grant;
         if (grant) begin
            bus.cmd_out       <= bus.req_cmd[grant_idx*CMD_WIDTH +: CMD_WIDTH];
            bus.cmd_tag_out   <= next_tag;
            bus.cmd_cu_id_out <= grant_idx;
         end
      end
   end

   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         bus.rsp_valid_out     <= '0;
         bus.rsp_tag_out       <= '0;
         bus.outstanding_count <= '0;
         bus.tag_error         <= 1'b0;
      end else begin
         bus.rsp_valid_out <= rsp_onehot;
         if (rsp_hit) bus.rsp_tag_out <= bus.rsp_tag_in;
         if (rsp_miss) bus.tag_error <= 1'b1;
         // Invalid responses never decrement, so the count cannot underflow.
         case ({grant, rsp_hit})
            2'b10:   bus.outstanding_count <= bus.outstanding_count + CNT_W'(1);
            2'b01:   bus.outstanding_count <= bus.outstanding_count - CNT_W'(1);
            default: ;
         endcase
      end
   end

   assert property (@(posedge clock) disable iff (rst) $onehot0(bus.req_ready));
   assert property (@(posedge clock) disable iff (rst)
                    bus.outstanding_count <= CNT_W'(CREDITS));

endmodule

// File: tb/tb_cu_command_arbiter.sv
// Directed bench for cu_command_arbiter: round-robin, fixed-priority and
// small-tag-space instances sharing one clock and reset.
module tb_cu_command_arbiter;

   localparam int CW = 16;

   logic clock = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   always #5 clock = ~clock;

   cu_command_arbiter_if #(.NUM_CU(4), .CMD_WIDTH(CW), .TAG_WIDTH(6), .CREDITS(32)) if_rr ();
   cu_command_arbiter_if #(.NUM_CU(4), .CMD_WIDTH(CW), .TAG_WIDTH(6), .CREDITS(32)) if_fp ();
   cu_command_arbiter_if #(.NUM_CU(4), .CMD_WIDTH(CW), .TAG_WIDTH(2), .CREDITS(4))  if_tw ();

   cu_command_arbiter #(.NUM_CU(4), .CMD_WIDTH(CW), .TAG_WIDTH(6), .CREDITS(32),
                        .PRIORITY_MODE(0)) u_rr (.clock(clock), .rst(rst), .bus(if_rr));
   cu_command_arbiter #(.NUM_CU(4), .CMD_WIDTH(CW), .TAG_WIDTH(6), .CREDITS(32),
                        .PRIORITY_MODE(1)) u_fp (.clock(clock), .rst(rst), .bus(if_fp));
   cu_command_arbiter #(.NUM_CU(4), .CMD_WIDTH(CW), .TAG_WIDTH(2), .CREDITS(4),
                        .PRIORITY_MODE(0)) u_tw (.clock(clock), .rst(rst), .bus(if_tw));

   task automatic tick();
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic idle_all();
      if_rr.enabled_in = 0; if_rr.req_valid = 0; if_rr.buffer_full_in = 0;
      if_rr.rsp_valid_in = 0; if_rr.rsp_tag_in = 0;
      if_rr.req_cmd = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
      if_fp.enabled_in = 0; if_fp.req_valid = 0; if_fp.buffer_full_in = 0;
      if_fp.rsp_valid_in = 0; if_fp.rsp_tag_in = 0;
      if_fp.req_cmd = {16'hB003, 16'hB002, 16'hB001, 16'hB000};
      if_tw.enabled_in = 0; if_tw.req_valid = 0; if_tw.buffer_full_in = 0;
      if_tw.rsp_valid_in = 0; if_tw.rsp_tag_in = 0;
      if_tw.req_cmd = {16'hC003, 16'hC002, 16'hC001, 16'hC000};
   endtask

   task automatic test_reset();
      // Requests presented while reset is held must not be granted.
      if_rr.enabled_in = 1; if_rr.req_valid = 4'hF;
      @(negedge clock); #1;
      checks++;
      if (if_rr.req_ready !== 4'h0) begin
         failures++; $display("FAIL reset_req_ready: got %b, expected 0000", if_rr.req_ready);
      end
      if_rr.enabled_in = 0; if_rr.req_valid = 0;
      @(negedge clock);
      rst = 1'b0;
      #1;
      checks++;
      if (if_rr.cmd_valid_out !== 1'b0) begin
         failures++; $display("FAIL reset_cmd_valid: got %b, expected 0", if_rr.cmd_valid_out);
      end
      checks++;
      if (if_rr.outstanding_count !== 6'd0) begin
         failures++; $display("FAIL reset_count: got %0d, expected 0", if_rr.outstanding_count);
      end
      checks++;
      if (if_rr.tag_error !== 1'b0) begin
         failures++; $display("FAIL reset_tag_error: got %b, expected 0", if_rr.tag_error);
      end
      checks++;
      if (if_rr.rsp_valid_out !== 4'h0) begin
         failures++; $display("FAIL reset_rsp_valid: got %b, expected 0000", if_rr.rsp_valid_out);
      end
      checks++;
      if (if_tw.outstanding_count !== 3'd0) begin
         failures++; $display("FAIL reset_tw_count: got %0d, expected 0", if_tw.outstanding_count);
      end
   endtask

   task automatic test_round_robin();
      logic [3:0]  exp_ready;
      logic [15:0] exp_cmd;
      @(negedge clock);
      if_rr.enabled_in = 1; if_rr.req_valid = 4'hF;
      for (int k = 0; k < 32; k++) begin
         exp_ready = 4'b0001 << (k % 4);
         exp_cmd   = 16'hA000 + 16'(k % 4);
         #1;
         checks++;
         if (if_rr.req_ready !== exp_ready) begin
            failures++;
            $display("FAIL rr_ready[%0d]: got %b, expected %b", k, if_rr.req_ready, exp_ready);
         end
         tick();
         checks++;
         if (if_rr.cmd_valid_out !== 1'b1) begin
            failures++; $display("FAIL rr_cmd_valid[%0d]: got %b, expected 1", k, if_rr.cmd_valid_out);
         end
         checks++;
         if (if_rr.cmd_cu_id_out !== 2'(k % 4)) begin
            failures++;
            $display("FAIL rr_cu_id[%0d]: got %0d, expected %0d", k, if_rr.cmd_cu_id_out, k % 4);
         end
         checks++;
         if (if_rr.cmd_tag_out !== 6'(k)) begin
            failures++; $display("FAIL rr_tag[%0d]: got %0d, expected %0d", k, if_rr.cmd_tag_out, k);
         end
         checks++;
         if (if_rr.cmd_out !== exp_cmd) begin
            failures++; $display("FAIL rr_cmd[%0d]: got %h, expected %h", k, if_rr.cmd_out, exp_cmd);
         end
      end
      #1;
      checks++;
      if (if_rr.req_ready !== 4'h0) begin
         failures++; $display("FAIL rr_full_ready: got %b, expected 0000", if_rr.req_ready);
      end
      checks++;
      if (if_rr.outstanding_count !== 6'd32) begin
         failures++; $display("FAIL rr_full_count: got %0d, expected 32", if_rr.outstanding_count);
      end
      tick();
      checks++;
      if (if_rr.cmd_valid_out !== 1'b0) begin
         failures++; $display("FAIL rr_full_cmd_valid: got %b, expected 0", if_rr.cmd_valid_out);
      end
   endtask

   task automatic test_credit_return();
      @(negedge clock);
      if_rr.rsp_valid_in = 1; if_rr.rsp_tag_in = 6'd5;
      tick();
      if_rr.rsp_valid_in = 0;
      checks++;
      if (if_rr.rsp_valid_out !== 4'b0010) begin
         failures++; $display("FAIL cr_rsp_valid: got %b, expected 0010", if_rr.rsp_valid_out);
      end
      checks++;
      if (if_rr.rsp_tag_out !== 6'd5) begin
         failures++; $display("FAIL cr_rsp_tag: got %0d, expected 5", if_rr.rsp_tag_out);
      end
      checks++;
      if (if_rr.outstanding_count !== 6'd31) begin
         failures++; $display("FAIL cr_count: got %0d, expected 31", if_rr.outstanding_count);
      end
      #1;
      checks++;
      if (if_rr.req_ready !== 4'b0001) begin
         failures++; $display("FAIL cr_ready: got %b, expected 0001", if_rr.req_ready);
      end
      tick();
      checks++;
      if (if_rr.cmd_valid_out !== 1'b1 || if_rr.cmd_tag_out !== 6'd32 || if_rr.cmd_cu_id_out !== 2'd0) begin
         failures++;
         $display("FAIL cr_issue: got valid=%b tag=%0d cu=%0d, expected valid=1 tag=32 cu=0",
                  if_rr.cmd_valid_out, if_rr.cmd_tag_out, if_rr.cmd_cu_id_out);
      end
      checks++;
      if (if_rr.outstanding_count !== 6'd32) begin
         failures++; $display("FAIL cr_count_refill: got %0d, expected 32", if_rr.outstanding_count);
      end
      #1;
      checks++;
      if (if_rr.req_ready !== 4'h0) begin
         failures++; $display("FAIL cr_ready_refull: got %b, expected 0000", if_rr.req_ready);
      end
   endtask

   task automatic test_simultaneous();
      logic [3:0] exp_rsp;
      @(negedge clock);
      if_rr.req_valid = 0;
      for (int t = 6; t < 28; t++) begin
         if_rr.rsp_valid_in = 1; if_rr.rsp_tag_in = 6'(t);
         exp_rsp = 4'b0001 << (t % 4);
         tick();
         checks++;
         if (if_rr.rsp_valid_out !== exp_rsp) begin
            failures++;
            $display("FAIL drain_rsp[%0d]: got %b, expected %b", t, if_rr.rsp_valid_out, exp_rsp);
         end
      end
      if_rr.rsp_valid_in = 0;
      checks++;
      if (if_rr.outstanding_count !== 6'd10) begin
         failures++; $display("FAIL drain_count: got %0d, expected 10", if_rr.outstanding_count);
      end
      if_rr.req_valid = 4'hF; if_rr.rsp_valid_in = 1; if_rr.rsp_tag_in = 6'd28;
      #1;
      checks++;
      if (if_rr.req_ready !== 4'b0010) begin
         failures++; $display("FAIL sim_ready: got %b, expected 0010", if_rr.req_ready);
      end
      tick();
      if_rr.req_valid = 0; if_rr.rsp_valid_in = 0;
      checks++;
      if (if_rr.outstanding_count !== 6'd10) begin
         failures++; $display("FAIL sim_count: got %0d, expected 10", if_rr.outstanding_count);
      end
      checks++;
      if (if_rr.cmd_valid_out !== 1'b1 || if_rr.cmd_tag_out !== 6'd33 || if_rr.cmd_cu_id_out !== 2'd1) begin
         failures++;
         $display("FAIL sim_issue: got valid=%b tag=%0d cu=%0d, expected valid=1 tag=33 cu=1",
                  if_rr.cmd_valid_out, if_rr.cmd_tag_out, if_rr.cmd_cu_id_out);
      end
      checks++;
      if (if_rr.rsp_valid_out !== 4'b0001 || if_rr.rsp_tag_out !== 6'd28) begin
         failures++;
         $display("FAIL sim_rsp: got valid=%b tag=%0d, expected valid=0001 tag=28",
                  if_rr.rsp_valid_out, if_rr.rsp_tag_out);
      end
      tick();
      checks++;
      if (if_rr.cmd_valid_out !== 1'b0 || if_rr.rsp_valid_out !== 4'h0) begin
         failures++;
         $display("FAIL sim_idle: got cmd_valid=%b rsp_valid=%b, expected 0 and 0000",
                  if_rr.cmd_valid_out, if_rr.rsp_valid_out);
      end
   endtask

   task automatic test_enable_gating();
      @(negedge clock);
      if_rr.req_valid = 4'hF;
      tick();
      if_rr.enabled_in = 0;
      #1;
      checks++;
      if (if_rr.req_ready !== 4'h0) begin
         failures++; $display("FAIL en_ready: got %b, expected 0000", if_rr.req_ready);
      end
      checks++;
      if (if_rr.cmd_valid_out !== 1'b1 || if_rr.cmd_tag_out !== 6'd34 || if_rr.cmd_cu_id_out !== 2'd2) begin
         failures++;
         $display("FAIL en_issue: got valid=%b tag=%0d cu=%0d, expected valid=1 tag=34 cu=2",
                  if_rr.cmd_valid_out, if_rr.cmd_tag_out, if_rr.cmd_cu_id_out);
      end
      tick();
      checks++;
      if (if_rr.cmd_valid_out !== 1'b0 || if_rr.outstanding_count !== 6'd11) begin
         failures++;
         $display("FAIL en_stop: got valid=%b count=%0d, expected valid=0 count=11",
                  if_rr.cmd_valid_out, if_rr.outstanding_count);
      end
      if_rr.req_valid = 0;
   endtask

   task automatic test_fixed_priority();
      @(negedge clock);
      if_fp.enabled_in = 1; if_fp.req_valid = 4'b1010;
      for (int k = 0; k < 4; k++) begin
         #1;
         checks++;
         if (if_fp.req_ready !== 4'b0010) begin
            failures++; $display("FAIL fp_ready[%0d]: got %b, expected 0010", k, if_fp.req_ready);
         end
         tick();
         checks++;
         if (if_fp.cmd_valid_out !== 1'b1 || if_fp.cmd_cu_id_out !== 2'd1 ||
             if_fp.cmd_tag_out !== 6'(k) || if_fp.cmd_out !== 16'hB001) begin
            failures++;
            $display("FAIL fp_issue[%0d]: got valid=%b cu=%0d tag=%0d cmd=%h, expected 1 1 %0d b001",
                     k, if_fp.cmd_valid_out, if_fp.cmd_cu_id_out, if_fp.cmd_tag_out, if_fp.cmd_out, k);
         end
      end
      if_fp.buffer_full_in = 1; if_fp.rsp_valid_in = 1; if_fp.rsp_tag_in = 6'd2;
      #1;
      checks++;
      if (if_fp.req_ready !== 4'h0) begin
         failures++; $display("FAIL fp_full_ready: got %b, expected 0000", if_fp.req_ready);
      end
      tick();
      if_fp.rsp_valid_in = 0;
      checks++;
      if (if_fp.cmd_valid_out !== 1'b0) begin
         failures++; $display("FAIL fp_full_cmd_valid: got %b, expected 0", if_fp.cmd_valid_out);
      end
      checks++;
      if (if_fp.rsp_valid_out !== 4'b0010 || if_fp.outstanding_count !== 6'd3) begin
         failures++;
         $display("FAIL fp_full_rsp: got rsp=%b count=%0d, expected 0010 and 3",
                  if_fp.rsp_valid_out, if_fp.outstanding_count);
      end
      if_fp.buffer_full_in = 0;
      #1;
      checks++;
      if (if_fp.req_ready !== 4'b0010) begin
         failures++; $display("FAIL fp_resume_ready: got %b, expected 0010", if_fp.req_ready);
      end
      tick();
      if_fp.req_valid = 0;
      checks++;
      if (if_fp.cmd_tag_out !== 6'd4 || if_fp.cmd_cu_id_out !== 2'd1) begin
         failures++;
         $display("FAIL fp_resume_issue: got tag=%0d cu=%0d, expected tag=4 cu=1",
                  if_fp.cmd_tag_out, if_fp.cmd_cu_id_out);
      end
   endtask

   task automatic test_tag_wrap();
      @(negedge clock);
      if_tw.enabled_in = 1; if_tw.req_valid = 4'hF;
      for (int k = 0; k < 4; k++) begin
         tick();
         checks++;
         if (if_tw.cmd_valid_out !== 1'b1 || if_tw.cmd_tag_out !== 2'(k) || if_tw.cmd_cu_id_out !== 2'(k)) begin
            failures++;
            $display("FAIL tw_issue[%0d]: got valid=%b tag=%0d cu=%0d, expected 1 %0d %0d",
                     k, if_tw.cmd_valid_out, if_tw.cmd_tag_out, if_tw.cmd_cu_id_out, k, k);
         end
      end
      #1;
      checks++;
      if (if_tw.req_ready !== 4'h0 || if_tw.outstanding_count !== 3'd4) begin
         failures++;
         $display("FAIL tw_full: got ready=%b count=%0d, expected 0000 and 4",
                  if_tw.req_ready, if_tw.outstanding_count);
      end
      if_tw.rsp_valid_in = 1; if_tw.rsp_tag_in = 2'd1;
      tick();
      if_tw.rsp_valid_in = 0;
      checks++;
      if (if_tw.rsp_valid_out !== 4'b0010 || if_tw.outstanding_count !== 3'd3) begin
         failures++;
         $display("FAIL tw_rsp1: got rsp=%b count=%0d, expected 0010 and 3",
                  if_tw.rsp_valid_out, if_tw.outstanding_count);
      end
      #1;
      checks++;
      if (if_tw.req_ready !== 4'h0) begin
         failures++; $display("FAIL tw_collision_ready: got %b, expected 0000", if_tw.req_ready);
      end
      tick();
      checks++;
      if (if_tw.cmd_valid_out !== 1'b0) begin
         failures++; $display("FAIL tw_collision_issue: got %b, expected 0", if_tw.cmd_valid_out);
      end
      if_tw.rsp_valid_in = 1; if_tw.rsp_tag_in = 2'd0;
      tick();
      if_tw.rsp_valid_in = 0;
      checks++;
      if (if_tw.rsp_valid_out !== 4'b0001 || if_tw.outstanding_count !== 3'd2) begin
         failures++;
         $display("FAIL tw_rsp0: got rsp=%b count=%0d, expected 0001 and 2",
                  if_tw.rsp_valid_out, if_tw.outstanding_count);
      end
      #1;
      checks++;
      if (if_tw.req_ready !== 4'b0001) begin
         failures++; $display("FAIL tw_resume_ready: got %b, expected 0001", if_tw.req_ready);
      end
      tick();
      if_tw.req_valid = 0;
      checks++;
      if (if_tw.cmd_valid_out !== 1'b1 || if_tw.cmd_tag_out !== 2'd0 ||
          if_tw.cmd_cu_id_out !== 2'd0 || if_tw.outstanding_count !== 3'd3) begin
         failures++;
         $display("FAIL tw_resume_issue: got valid=%b tag=%0d cu=%0d count=%0d, expected 1 0 0 3",
                  if_tw.cmd_valid_out, if_tw.cmd_tag_out, if_tw.cmd_cu_id_out, if_tw.outstanding_count);
      end
   endtask

   task automatic test_error_reset();
      @(negedge clock);
      if_rr.rsp_valid_in = 1; if_rr.rsp_tag_in = 6'd7;
      tick();
      if_rr.rsp_valid_in = 0;
      checks++;
      if (if_rr.tag_error !== 1'b1 || if_rr.rsp_valid_out !== 4'h0 || if_rr.outstanding_count !== 6'd11) begin
         failures++;
         $display("FAIL err_bad_tag: got err=%b rsp=%b count=%0d, expected 1 0000 11",
                  if_rr.tag_error, if_rr.rsp_valid_out, if_rr.outstanding_count);
      end
      tick();
      checks++;
      if (if_rr.tag_error !== 1'b1) begin
         failures++; $display("FAIL err_sticky: got %b, expected 1", if_rr.tag_error);
      end
      if_rr.enabled_in = 1; if_rr.req_valid = 4'hF;
      tick();
      tick();
      checks++;
      if (if_rr.cmd_valid_out !== 1'b1 || if_rr.outstanding_count !== 6'd13) begin
         failures++;
         $display("FAIL err_burst: got valid=%b count=%0d, expected 1 and 13",
                  if_rr.cmd_valid_out, if_rr.outstanding_count);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (if_rr.cmd_valid_out !== 1'b0 || if_rr.outstanding_count !== 6'd0 || if_rr.tag_error !== 1'b0 ||
          if_rr.req_ready !== 4'h0 || if_rr.rsp_valid_out !== 4'h0 || if_rr.cmd_tag_out !== 6'd0 ||
          if_rr.cmd_cu_id_out !== 2'd0 || if_rr.cmd_out !== 16'h0 || if_rr.rsp_tag_out !== 6'd0) begin
         failures++;
         $display("FAIL rst_mid: got valid=%b count=%0d err=%b ready=%b rsp=%b tag=%0d cu=%0d cmd=%h rtag=%0d, expected all 0",
                  if_rr.cmd_valid_out, if_rr.outstanding_count, if_rr.tag_error, if_rr.req_ready,
                  if_rr.rsp_valid_out, if_rr.cmd_tag_out, if_rr.cmd_cu_id_out, if_rr.cmd_out,
                  if_rr.rsp_tag_out);
      end
      if_rr.req_valid = 0; if_rr.enabled_in = 0;
      @(negedge clock);
      rst = 1'b0;
      if_rr.rsp_valid_in = 1; if_rr.rsp_tag_in = 6'd35;
      tick();
      if_rr.rsp_valid_in = 0;
      checks++;
      if (if_rr.tag_error !== 1'b1 || if_rr.rsp_valid_out !== 4'h0 || if_rr.outstanding_count !== 6'd0) begin
         failures++;
         $display("FAIL rst_stale_rsp: got err=%b rsp=%b count=%0d, expected 1 0000 0",
                  if_rr.tag_error, if_rr.rsp_valid_out, if_rr.outstanding_count);
      end
   endtask

   initial begin
      rst = 1'b1;
      idle_all();
      test_reset();
      test_round_robin();
      test_credit_return();
      test_simultaneous();
      test_enable_gating();
      test_fixed_priority();
      test_tag_wrap();
      test_error_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

endmodule
